hs_rx_buffer: RTL and testbench

HS_RX_BUFFER -- requirements
Module: hs_rx_buffer

---
 rtl/hs_rx_buffer_pkg.sv | 21 ++
 rtl/hs_rx_fifo.sv | 68 ++++++
 rtl/hs_rx_buffer.sv | 97 +++++++++
 tb/tb_hs_rx_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hs_rx_buffer_pkg.sv
// Shared handshake parameters: default word width and depth, pointer-width
// derivation and the occupancy state encoding used by the receive buffer.
`timescale 1ns/1ps
package hs_rx_buffer_pkg;

  localparam int unsigned HS_WIDTH = 32;
  localparam int unsigned HS_DEPTH = 4;

  // Pointer width for a power-of-two depth; a one-entry buffer still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StAlmost,
    StFull
  } occ_state_e;

endpackage

// File: rtl/hs_rx_fifo.sv
// Storage and pointers for the receive buffer. The push and pop inputs are
// already qualified by the parent, so this block never sees an overflowing
// push or an empty pop.
`timescale 1ns/1ps
module hs_rx_fifo
  import hs_rx_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH,
  parameter int unsigned DEPTH = HS_DEPTH,
  localparam int unsigned PW = ptr_width(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  // Storage is cleared on reset so an empty buffer reads back zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head word is presented straight from storage with no added latency.
  always_comb begin
    rdata = mem[head];
    count = cnt;
  end

endmodule

// File: rtl/hs_rx_buffer.sv
// Receiving end of the 4-phase request/acknowledge synchronizer. Buffers
// words from the destination side, applies backpressure one slot early so the
// single in-flight word always fits, and tracks overflow and accepted words.
`timescale 1ns/1ps
module hs_rx_buffer
  import hs_rx_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH,
  parameter int unsigned DEPTH = HS_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hs_valid,
  input  logic [WIDTH-1:0]          hs_data,
  output logic                      hs_busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ptr_width(DEPTH):0] count,
  output logic                      ovf_err,
  output logic [15:0]               rx_cnt
);

  localparam int unsigned CW = ptr_width(DEPTH) + 1;
  localparam logic [CW-1:0] CntFull   = CW'(DEPTH);
  localparam logic [CW-1:0] CntAlmost = CW'(DEPTH - 1);

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;
  occ_state_e    state;

  hs_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (hs_data),
    .rdata (out_data),
    .count (fifo_count)
  );

  // Push/pop qualification; a pop at full frees the slot for a same-edge push.
  always_comb begin
    full      = (fifo_count == CntFull);
    pop       = out_valid & out_ready;
    accept    = hs_valid & (~full | pop);
    drop      = hs_valid & full & ~pop;
    count_nxt = fifo_count;
    if (accept & ~pop)      count_nxt = fifo_count + CW'(1);
    else if (pop & ~accept) count_nxt = fifo_count - CW'(1);
  end

  // Occupancy state follows the next count so it stays aligned with the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StEmpty;
    end else begin
      if (count_nxt == '0)             state <= StEmpty;
      else if (count_nxt == CntFull)   state <= StFull;
      else if (count_nxt == CntAlmost) state <= StAlmost;
      else                             state <= StPartial;
    end
  end

  // Sticky overflow flag: a word arrived with no room and no same-edge pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (drop) begin
      ovf_err <= 1'b1;
    end
  end

  // Accepted-word counter, wraps at 16 bits; dropped words are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
    end else if (accept) begin
      rx_cnt <= rx_cnt + 16'd1;
    end
  end

  // Outputs decoded from the registered occupancy state.
  always_comb begin
    out_valid = (state != StEmpty);
    hs_busy   = (state == StAlmost) || (state == StFull);
    count     = fifo_count;
  end

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Self-checking bench for hs_rx_buffer: directed scenarios plus randomized
// traffic, checked against a queue-based occupancy model and a data scoreboard.
`timescale 1ns/1ps
module tb_hs_rx_buffer;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hs_valid = 1'b0;
  logic [W-1:0] hs_data = '0;
  logic         out_ready = 1'b0;
  logic         hs_busy;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         ovf_err;
  logic [15:0]  rx_cnt;

  int checks = 0;
  int failures = 0;
  int popped = 0;

  // Reference model: expected words in arrival order plus scalar status.
  logic [W-1:0] sb[$];
  int           m_cnt;
  logic         m_ovf;
  int           m_rx;

  hs_rx_buffer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hs_valid  (hs_valid),
    .hs_data   (hs_data),
    .hs_busy   (hs_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovf_err   (ovf_err),
    .rx_cnt    (rx_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_rx  = 0;
  endtask

  // Apply one cycle of inputs, then advance the model by the rules of the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    logic do_pop;
    logic do_acc;
    hs_valid  = v;
    hs_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else begin
      do_pop = (m_cnt > 0) && r;
      do_acc = v && ((m_cnt < D) || do_pop);
      if (do_pop) m_cnt--;
      if (do_acc) begin
        m_cnt++;
        sb.push_back(d);
        m_rx = (m_rx + 1) % 65536;
      end
      if (v && !do_acc) m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    hs_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hs_busy", 64'(hs_busy), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    chk("rst_rx_cnt", 64'(rx_cnt), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_out_data", 64'(out_data), 64'd0);
  endtask

  // Monitor: status against the model each cycle, data popped on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_count", 64'(count), 64'(m_cnt));
      chk("mon_out_valid", 64'(out_valid), 64'(m_cnt != 0));
      chk("mon_hs_busy", 64'(hs_busy), 64'(m_cnt >= D - 1));
      chk("mon_ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("mon_rx_cnt", 64'(rx_cnt), 64'(m_rx));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_word actual=%0h expected=none", out_data);
        end else begin
          chk("mon_out_data", 64'(out_data), 64'(sb.pop_front()));
          popped++;
        end
      end
    end
  end

  initial begin
    int base;

    do_reset();

    // Single push reaches the output one edge later.
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_out_data", 64'(out_data), 64'hA5A5_0001);
    chk("first_count", 64'(count), 64'd1);

    // Reset with a word buffered discards it.
    do_reset();

    // Fill: busy at three, fourth word still fits, fifth is dropped.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    chk("fill3_hs_busy", 64'(hs_busy), 64'd1);
    chk("fill3_count", 64'(count), 64'd3);
    cycle(1'b1, 32'hB000_0004, 1'b0);
    chk("fill4_count", 64'(count), 64'd4);
    chk("fill4_ovf_err", 64'(ovf_err), 64'd0);
    cycle(1'b1, 32'hB000_0005, 1'b0);
    chk("drop_ovf_err", 64'(ovf_err), 64'd1);
    chk("drop_rx_cnt", 64'(rx_cnt), 64'd4);
    chk("drop_head", 64'(out_data), 64'hB000_0001);
    chk("drop_count", 64'(count), 64'd4);
    repeat (5) cycle(1'b0, '0, 1'b1);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // Push and pop together while full.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
    cycle(1'b1, 32'hC000_0005, 1'b1);
    chk("full_pp_count", 64'(count), 64'd4);
    chk("full_pp_ovf_err", 64'(ovf_err), 64'd0);
    chk("full_pp_rx_cnt", 64'(rx_cnt), 64'd5);
    chk("full_pp_head", 64'(out_data), 64'hC000_0002);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Stream 1..10 with out_ready toggling; order checked by the scoreboard.
    do_reset();
    base = popped;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 32'(i), 1'b1);
      cycle(1'b0, '0, 1'b0);
    end
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("stream_rx_cnt", 64'(rx_cnt), 64'd10);
    chk("stream_ovf_err", 64'(ovf_err), 64'd0);
    chk("stream_popped", 64'(popped - base), 64'd10);

    // Randomized traffic, including overflow, with a reset in the middle.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
    end
    repeat (D + 2) cycle(1'b0, '0, 1'b1);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
